// File: rtl/stride_prefetcher_pkg.sv
// prefetch_types: shared types for the stride prefetcher.
//   rpt_state_t : per-entry stride confidence state
//   pf_fsm_t    : prefetch issue handshake state
//   rpt_entry_t : one reference prediction table entry
// Entry fields are sized by RPT_ADDR_W; the prefetcher's ADDR_W defaults to it
// and must match it. The tag field is kept full-width, holding the PC shifted
// right past the index and byte-offset bits.
package prefetch_types;

    localparam int unsigned RPT_ADDR_W = 32;

    typedef enum logic [1:0] {
        RPT_INIT,
        RPT_TRANSIENT,
        RPT_STEADY,
        RPT_NOPRED
    } rpt_state_t;

    typedef enum logic {
        PF_IDLE,
        PF_REQ
    } pf_fsm_t;

    typedef struct packed {
        logic                  valid;
        logic [RPT_ADDR_W-1:0] tag;
        logic [RPT_ADDR_W-1:0] last_addr;
        logic [RPT_ADDR_W-1:0] stride;
        rpt_state_t            state;
    } rpt_entry_t;

endpackage

// File: rtl/stride_prefetcher_rpt_table.sv
// rpt_table: reference prediction table storage.
//   clk, rst_n  : clock, asynchronous active-low reset (clears every entry)
//   rd_idx_i    : lookup index; rd_entry_o is the combinational read-out
//   wr_en_i     : write strobe; wr_entry_i stored at wr_idx_i on the rising edge
module rpt_table
    import prefetch_types::*;
#(
    parameter  int unsigned ENTRIES = 16,
    localparam int unsigned IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx_i,
    output rpt_entry_t       rd_entry_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  rpt_entry_t       wr_entry_i
);

    rpt_entry_t entries_q [ENTRIES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                entries_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            entries_q[wr_idx_i] <= wr_entry_i;
        end
    end

    assign rd_entry_o = entries_q[rd_idx_i];

endmodule

// File: rtl/stride_prefetcher.sv
// stride_prefetcher: PC-indexed stride prefetcher for the data side.
//   clk, rst_n        : clock, asynchronous active-low reset
//   pf_enable         : allow new prefetch issues (training continues regardless)
//   access_valid      : one-cycle pulse per completed dcache access
//   access_pc/addr    : PC and effective address of that access
//   pf_read/pf_addr   : line-aligned prefetch read, held until pf_resp
//   pf_resp           : one-cycle acceptance of the outstanding read
//   pf_issued_count   : completed prefetches, saturating
//   pf_dropped_count  : candidates lost to an in-flight request, saturating
module stride_prefetcher
    import prefetch_types::*;
#(
    parameter int unsigned ENTRIES    = 16,
    parameter int unsigned ADDR_W     = RPT_ADDR_W,
    parameter int unsigned LINE_BYTES = 32,
    parameter int unsigned DEGREE     = 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pf_enable,
    input  logic              access_valid,
    input  logic [ADDR_W-1:0] access_pc,
    input  logic [ADDR_W-1:0] access_addr,
    output logic              pf_read,
    output logic [ADDR_W-1:0] pf_addr,
    input  logic              pf_resp,
    output logic [CNT_W-1:0]  pf_issued_count,
    output logic [CNT_W-1:0]  pf_dropped_count
);

    localparam int unsigned       IDX_W     = $clog2(ENTRIES);
    localparam int unsigned       TAG_SHIFT = IDX_W + 2;
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_BYTES - 1);

    // ---------------- table lookup ----------------
    logic [IDX_W-1:0]  idx;
    logic [ADDR_W-1:0] tag_in;
    rpt_entry_t        rd_entry;
    rpt_entry_t        upd_entry;
    logic              hit;
    logic [ADDR_W-1:0] new_stride;
    logic              correct;

    assign idx        = access_pc[IDX_W+1:2];
    assign tag_in     = access_pc >> TAG_SHIFT;
    assign hit        = rd_entry.valid && (rd_entry.tag == tag_in);
    assign new_stride = access_addr - rd_entry.last_addr;
    assign correct    = (new_stride == rd_entry.stride);

    rpt_table #(
        .ENTRIES (ENTRIES)
    ) u_rpt_table (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_idx_i   (idx),
        .rd_entry_o (rd_entry),
        .wr_en_i    (access_valid),
        .wr_idx_i   (idx),
        .wr_entry_i (upd_entry)
    );

    always_comb begin
        upd_entry           = rd_entry;
        upd_entry.valid     = 1'b1;
        upd_entry.tag       = tag_in;
        upd_entry.last_addr = access_addr;
        if (!hit) begin
            upd_entry.stride = '0;
            upd_entry.state  = RPT_INIT;
        end else begin
            unique case (rd_entry.state)
                RPT_INIT: begin
                    if (correct) begin
                        upd_entry.state = RPT_STEADY;
                    end else begin
                        upd_entry.state  = RPT_TRANSIENT;
                        upd_entry.stride = new_stride;
                    end
                end
                RPT_TRANSIENT: begin
                    if (correct) begin
                        upd_entry.state = RPT_STEADY;
                    end else begin
                        upd_entry.state  = RPT_NOPRED;
                        upd_entry.stride = new_stride;
                    end
                end
                // A single miss in STEADY keeps the learned stride.
                RPT_STEADY: begin
                    upd_entry.state = correct ? RPT_STEADY : RPT_INIT;
                end
                RPT_NOPRED: begin
                    if (correct) begin
                        upd_entry.state = RPT_TRANSIENT;
                    end else begin
                        upd_entry.state  = RPT_NOPRED;
                        upd_entry.stride = new_stride;
                    end
                end
                default: begin
                    upd_entry.state = RPT_INIT;
                end
            endcase
        end
    end

    // ---------------- candidate generation ----------------
    logic [ADDR_W-1:0] cand_line;
    logic [ADDR_W-1:0] access_line;
    logic              cand_raw;
    logic              cand_valid;
    logic              last_valid_q, last_valid_d;
    logic [ADDR_W-1:0] last_line_q, last_line_d;

    assign cand_line   = (access_addr + ADDR_W'(DEGREE) * upd_entry.stride) & LINE_MASK;
    assign access_line = access_addr & LINE_MASK;
    assign cand_raw    = access_valid && pf_enable &&
                         (upd_entry.state == RPT_STEADY) && (upd_entry.stride != '0);
    assign cand_valid  = cand_raw && (cand_line != access_line) &&
                         !(last_valid_q && (cand_line == last_line_q));

    // ---------------- issue FSM and counters ----------------
    pf_fsm_t           state_q, state_d;
    logic [ADDR_W-1:0] pf_addr_q, pf_addr_d;
    logic [CNT_W-1:0]  issued_q, issued_d;
    logic [CNT_W-1:0]  dropped_q, dropped_d;

    always_comb begin
        state_d      = state_q;
        pf_addr_d    = pf_addr_q;
        issued_d     = issued_q;
        dropped_d    = dropped_q;
        last_valid_d = last_valid_q;
        last_line_d  = last_line_q;
        unique case (state_q)
            PF_IDLE: begin
                if (cand_valid) begin
                    state_d   = PF_REQ;
                    pf_addr_d = cand_line;
                end
            end
            PF_REQ: begin
                // Candidates seen during REQ are dropped, including the pf_resp cycle.
                if (cand_valid && (dropped_q != '1)) begin
                    dropped_d = dropped_q + 1'b1;
                end
                if (pf_resp) begin
                    state_d      = PF_IDLE;
                    last_valid_d = 1'b1;
                    last_line_d  = pf_addr_q;
                    if (issued_q != '1) begin
                        issued_d = issued_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = PF_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= PF_IDLE;
            pf_addr_q    <= '0;
            issued_q     <= '0;
            dropped_q    <= '0;
            last_valid_q <= 1'b0;
            last_line_q  <= '0;
        end else begin
            state_q      <= state_d;
            pf_addr_q    <= pf_addr_d;
            issued_q     <= issued_d;
            dropped_q    <= dropped_d;
            last_valid_q <= last_valid_d;
            last_line_q  <= last_line_d;
        end
    end

    assign pf_read          = (state_q == PF_REQ);
    assign pf_addr          = pf_addr_q;
    assign pf_issued_count  = issued_q;
    assign pf_dropped_count = dropped_q;

endmodule
